uart_line_editor: RTL and testbench
===================================

# uart_line_editor

Line-editing stage directly downstream of the UART controller's receive path and upstream of its transmit path. Accepts received bytes (`RX_DAT`/`RX_VALID`), builds a command line in an internal buffer with backspace handling, and echoes the edits back through the transmitter's SEND/READY handshake. On carriage return it presents the completed line to the command logic and holds it until acknowledged.

## Interface
- `MAX_LEN`, 32: line buffer depth in bytes, at least 2.
- `ADDR_W`, `$clog2(MAX_LEN)`: buffer address width.
- `CLK` in 1: system clock.
- `RST` in 1: asynchronous, active-high reset.
- `RX_DAT` in 8: received byte, from UART controller `UART_RX_DAT`.
- `RX_VALID` in 1: single-cycle strobe, `RX_DAT` valid.
- `TX_DAT` out 8: echo byte, to `UART_TX_DAT`.
- `TX_SEND` out 1: single-cycle send strobe, to `UART_TX_SEND`.
- `TX_READY` in 1: transmitter idle, from `UART_TX_READY`.
- `LINE_VALID` out 1: completed line available.
- `LINE_LEN` out ADDR_W+1: byte count of completed line.
- `LINE_RD_ADDR` in ADDR_W: buffer read address.
- `LINE_RD_DAT` out 8: registered buffer read data.
- `LINE_ACK` in 1: consumer done, release line.
- `OVERFLOW` out 1: sticky, at least one printable byte was dropped because the buffer was full.
- `RX_DROP` out 1: sticky, at least one byte arrived while the block was busy.

## Operation
- FSM states: IDLE, SEND, GUARD, WAIT, LINE.
- Echo queue: up to 3 bytes plus a count. Bytes are sent in order.
- RX_VALID is accepted only in IDLE. In any other state the byte is discarded and RX_DROP is set.
- Byte classes, handled in IDLE:
  - Printable 0x20–0x7E with len<MAX_LEN: write `buf[len]`, len+1, queue the byte.
  - Printable with len==MAX_LEN: no write, set OVERFLOW, queue 0x07.
  - 0x08 or 0x7F with len>0: len−1, queue 0x08, 0x20, 0x08.
  - 0x08 or 0x7F with len==0: no action, stay IDLE.
  - 0x0D: queue 0x0D, 0x0A, and mark line-pending.
  - Any other byte, including 0x0A: ignored.
- A non-empty queue moves the FSM IDLE→SEND.
- In SEND, wait for TX_READY=1. Then drive `TX_DAT` = queue head, pulse `TX_SEND` for 1 cycle, pop the queue, and go to GUARD.
- GUARD lasts 1 cycle and ignores TX_READY, covering the transmitter's READY deassert latency. GUARD→WAIT.
- In WAIT, once TX_READY=1: go to SEND if the queue is non-empty. Otherwise go to LINE if line-pending, else IDLE.
- LINE: `LINE_VALID`=1 and `LINE_LEN`=len, both held stable. On LINE_ACK: len=0, OVERFLOW=0, RX_DROP=0, LINE_VALID=0, next state IDLE.
- LINE_ACK outside LINE is ignored.
- Read port: `LINE_RD_DAT` = `buf[LINE_RD_ADDR]`, registered, in every state. An address ≥MAX_LEN returns 0x00. Buffer contents are not cleared on ACK or reset.
- Length arithmetic is unsigned, ADDR_W+1 bits. len never exceeds MAX_LEN and never goes below 0.

## Timing
- Reset values: `TX_DAT`=0x00, `TX_SEND`=0, `LINE_VALID`=0, `LINE_LEN`=0, `LINE_RD_DAT`=0x00, `OVERFLOW`=0, `RX_DROP`=0. Internal: len=0, queue empty, state IDLE.
- Reset asserted mid-echo or mid-LINE clears the FSM, queue and len immediately. `TX_SEND` must never glitch high during reset.
- RX_VALID in IDLE at edge N: buffer write and len update visible at N+1, FSM in SEND at N+1. With TX_READY=1, `TX_SEND` is high during cycle N+1 and `TX_DAT` is valid in the same cycle.
- `TX_DAT` holds its value until the next `TX_SEND`.
- Minimum spacing between TX_SEND pulses is 3 cycles: SEND, GUARD, WAIT.
- `LINE_VALID` rises the cycle after the WAIT that observes TX_READY=1 following the 0x0A echo.
- LINE_ACK at edge M: `LINE_VALID`=0 and state IDLE at M+1. RX_VALID in the same cycle as LINE_ACK is dropped and sets RX_DROP, but that RX_DROP is cleared by the ACK.
- `LINE_RD_DAT` latency is 1 cycle from `LINE_RD_ADDR`.

## Test plan
- Reset, then RX "AB", 0x0D, with TX_READY modelled as 1 idle / 0 for 10 cycles after each SEND. Required: TX stream 0x41, 0x42, 0x0D, 0x0A. Then LINE_VALID=1, LINE_LEN=2, reading addr0/addr1 gives 0x41/0x42. LINE_ACK gives LINE_VALID=0.
- RX "ABC", 0x08, 0x0D. Required: echoes 0x41 0x42 0x43 0x08 0x20 0x08 0x0D 0x0A, then LINE_LEN=2.
- RX 0x7F with an empty buffer. Required: no TX_SEND, state stays IDLE, len=0.
- MAX_LEN=4: RX "ABCDE", 0x0D. Required: fifth echo is 0x07, OVERFLOW=1, LINE_LEN=4. After LINE_ACK, OVERFLOW=0.
- RX a second byte while the first echo is in WAIT. Required: second byte not stored, RX_DROP=1, only one echo sent.
- Assert RST while TX_SEND would fire and LINE_VALID=1. Required: all outputs at reset values immediately, no further TX_SEND until the next RX byte.

Source files
------------

// File: rtl/uart_line_editor.sv
// Command-line editor between the UART receive and transmit paths: buffers printable bytes,
// handles backspace, echoes edits and presents a completed line on carriage return.
module uart_line_editor #(
  parameter int MAX_LEN = 32,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_DAT,
  input  logic              RX_VALID,
  output logic [7:0]        TX_DAT,
  output logic              TX_SEND,
  input  logic              TX_READY,
  output logic              LINE_VALID,
  output logic [ADDR_W:0]   LINE_LEN,
  input  logic [ADDR_W-1:0] LINE_RD_ADDR,
  output logic [7:0]        LINE_RD_DAT,
  input  logic              LINE_ACK,
  output logic              OVERFLOW,
  output logic              RX_DROP
);

  // state | meaning
  // IDLE  | accepting received bytes, echo queue empty
  // SEND  | waiting for TX_READY, then send queue head
  // GUARD | one cycle while the transmitter drops READY
  // WAIT  | waiting for the transmitter to finish the byte
  // LINE  | completed line held until LINE_ACK
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT, S_LINE} state_t;

  localparam logic [ADDR_W:0] MAX_LEN_L = (ADDR_W+1)'(MAX_LEN);

  state_t          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [7:0]      q0_q, q0_d, q1_q, q1_d, q2_q, q2_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [7:0]      tx_dat_q, tx_dat_d;
  logic            line_valid_q, line_valid_d;
  logic            ovf_q, ovf_d;
  logic            drop_q, drop_d;
  logic [7:0]      rd_dat_q, rd_dat_d;
  logic            wr_en;
  logic            tx_send;
  logic [7:0]      buf_mem [MAX_LEN];

  // Send fires in the same cycle READY is seen so the first echo leaves one cycle after RX.
  assign tx_send = (state_q == S_SEND) && TX_READY;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    q0_d         = q0_q;
    q1_d         = q1_q;
    q2_d         = q2_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    tx_dat_d     = tx_dat_q;
    line_valid_d = line_valid_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    wr_en        = 1'b0;
    rd_dat_d     = ({1'b0, LINE_RD_ADDR} < MAX_LEN_L) ? buf_mem[LINE_RD_ADDR] : 8'h00;

    if (RX_VALID && state_q != S_IDLE) drop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (RX_VALID) begin
          if (RX_DAT >= 8'h20 && RX_DAT <= 8'h7E) begin
            cnt_d   = 2'd1;
            state_d = S_SEND;
            if (len_q < MAX_LEN_L) begin
              wr_en = 1'b1;
              len_d = len_q + 1'b1;
              q0_d  = RX_DAT;
            end else begin
              ovf_d = 1'b1;
              q0_d  = 8'h07;
            end
          end else if (RX_DAT == 8'h08 || RX_DAT == 8'h7F) begin
            if (len_q != '0) begin
              len_d   = len_q - 1'b1;
              q0_d    = 8'h08;
              q1_d    = 8'h20;
              q2_d    = 8'h08;
              cnt_d   = 2'd3;
              state_d = S_SEND;
            end
          end else if (RX_DAT == 8'h0D) begin
            q0_d    = 8'h0D;
            q1_d    = 8'h0A;
            cnt_d   = 2'd2;
            pend_d  = 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (TX_READY) begin
          tx_dat_d = q0_q;
          q0_d     = q1_q;
          q1_d     = q2_q;
          q2_d     = 8'h00;
          cnt_d    = cnt_q - 1'b1;
          state_d  = S_GUARD;
        end
      end
      S_GUARD: state_d = S_WAIT;
      S_WAIT: begin
        if (TX_READY) begin
          if (cnt_q != 2'd0) begin
            state_d = S_SEND;
          end else if (pend_q) begin
            pend_d       = 1'b0;
            line_valid_d = 1'b1;
            state_d      = S_LINE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LINE: begin
        if (LINE_ACK) begin
          len_d        = '0;
          ovf_d        = 1'b0;
          drop_d       = 1'b0;
          line_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      q0_q         <= 8'h00;
      q1_q         <= 8'h00;
      q2_q         <= 8'h00;
      cnt_q        <= 2'd0;
      pend_q       <= 1'b0;
      tx_dat_q     <= 8'h00;
      line_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= 1'b0;
      rd_dat_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      q0_q         <= q0_d;
      q1_q         <= q1_d;
      q2_q         <= q2_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      tx_dat_q     <= tx_dat_d;
      line_valid_q <= line_valid_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      rd_dat_q     <= rd_dat_d;
    end
  end

  // Line storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_en) buf_mem[len_q[ADDR_W-1:0]] <= RX_DAT;
  end

  assign TX_SEND     = tx_send;
  assign TX_DAT      = tx_send ? q0_q : tx_dat_q;
  assign LINE_VALID  = line_valid_q;
  assign LINE_LEN    = len_q;
  assign LINE_RD_DAT = rd_dat_q;
  assign OVERFLOW    = ovf_q;
  assign RX_DROP     = drop_q;

endmodule

// File: tb/tb_uart_line_editor.sv
// Directed bench for uart_line_editor: two instances (depth 6 and depth 4) share RX stimulus,
// each with its own transmitter model and echo capture.
module tb_uart_line_editor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_dat = 8'h00;
  logic       rx_valid = 1'b0;
  logic       line_ack = 1'b0;

  logic [7:0] tx_dat_a, tx_dat_b, rd_dat_a, rd_dat_b;
  logic       tx_send_a, tx_send_b, rdy_a, rdy_b;
  logic       lv_a, lv_b, ovf_a, ovf_b, drop_a, drop_b;
  logic [3:0] len_a;
  logic [2:0] len_b;
  logic [2:0] rd_addr_a = 3'd0;
  logic [1:0] rd_addr_b = 2'd0;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  logic       seen_a = 1'b0, seen_b = 1'b0;
  int         busy_a = 0, busy_b = 0;

  always #5 clk = ~clk;

  uart_line_editor #(.MAX_LEN(6)) dut_a (
    .CLK(clk), .RST(rst), .RX_DAT(rx_dat), .RX_VALID(rx_valid),
    .TX_DAT(tx_dat_a), .TX_SEND(tx_send_a), .TX_READY(rdy_a),
    .LINE_VALID(lv_a), .LINE_LEN(len_a), .LINE_RD_ADDR(rd_addr_a),
    .LINE_RD_DAT(rd_dat_a), .LINE_ACK(line_ack), .OVERFLOW(ovf_a), .RX_DROP(drop_a)
  );

  uart_line_editor #(.MAX_LEN(4)) dut_b (
    .CLK(clk), .RST(rst), .RX_DAT(rx_dat), .RX_VALID(rx_valid),
    .TX_DAT(tx_dat_b), .TX_SEND(tx_send_b), .TX_READY(rdy_b),
    .LINE_VALID(lv_b), .LINE_LEN(len_b), .LINE_RD_ADDR(rd_addr_b),
    .LINE_RD_DAT(rd_dat_b), .LINE_ACK(line_ack), .OVERFLOW(ovf_b), .RX_DROP(drop_b)
  );

  // Transmitter model: ready when idle, busy for 10 cycles after each send.
  assign rdy_a = (busy_a == 0);
  assign rdy_b = (busy_b == 0);

  always @(negedge clk) begin
    seen_a = tx_send_a;
    seen_b = tx_send_b;
    if (tx_send_a) got_a.push_back(tx_dat_a);
    if (tx_send_b) got_b.push_back(tx_dat_b);
  end

  always @(posedge clk) begin
    if (seen_a) busy_a <= 10; else if (busy_a != 0) busy_a <= busy_a - 1;
    if (seen_b) busy_b <= 10; else if (busy_b != 0) busy_b <= busy_b - 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_dat   = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_rx(s[i]);
      cycles(45);
    end
  endtask

  task automatic push_exp(input string s, input bit to_a, input bit to_b);
    for (int i = 0; i < s.len(); i++) begin
      if (to_a) exp_a.push_back(s[i]);
      if (to_b) exp_b.push_back(s[i]);
    end
  endtask

  task automatic check_streams(input string tag);
    chk({tag, "_a_cnt"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      chk($sformatf("%s_a_byte%0d", tag, i), got_a[i], exp_a[i]);
    chk({tag, "_b_cnt"}, got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      chk($sformatf("%s_b_byte%0d", tag, i), got_b[i], exp_b[i]);
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic ack_line(input bit with_rx);
    @(negedge clk);
    line_ack = 1'b1;
    rx_dat   = 8'h58;
    rx_valid = with_rx;
    @(negedge clk);
    line_ack = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic read_both(input logic [2:0] aa, input logic [1:0] ab);
    @(negedge clk);
    rd_addr_a = aa;
    rd_addr_b = ab;
    @(negedge clk);
  endtask

  initial begin
    cycles(3);
    chk("rst_tx_send", {tx_send_a, tx_send_b}, 2'b00);
    chk("rst_tx_dat", {tx_dat_a, tx_dat_b}, 16'h0000);
    chk("rst_line_valid", {lv_a, lv_b}, 2'b00);
    chk("rst_line_len", {len_a, 1'b0, len_b}, 8'h00);
    chk("rst_rd_dat", {rd_dat_a, rd_dat_b}, 16'h0000);
    chk("rst_flags", {ovf_a, ovf_b, drop_a, drop_b}, 4'h0);
    rst = 1'b0;
    cycles(2);

    // "AB" CR, with first-echo latency check
    send_rx(8'h41);
    chk("lat_tx_send", {tx_send_a, tx_send_b}, 2'b11);
    chk("lat_tx_dat", {tx_dat_a, tx_dat_b}, 16'h4141);
    chk("lat_len", {len_a, 1'b0, len_b}, 8'h11);
    cycles(45);
    chk("hold_tx_dat", tx_dat_a, 8'h41);
    send_str("B\r");
    push_exp("AB\r\n", 1, 1);
    check_streams("ab");
    chk("ab_line_valid", {lv_a, lv_b}, 2'b11);
    chk("ab_line_len_a", len_a, 4'd2);
    chk("ab_line_len_b", len_b, 3'd2);
    read_both(3'd0, 2'd0);
    chk("ab_rd0", {rd_dat_a, rd_dat_b}, 16'h4141);
    read_both(3'd1, 2'd1);
    chk("ab_rd1", {rd_dat_a, rd_dat_b}, 16'h4242);
    ack_line(0);
    chk("ab_ack_line_valid", {lv_a, lv_b}, 2'b00);
    chk("ab_ack_len", {len_a, 1'b0, len_b}, 8'h00);

    // "ABC" BS CR
    send_str("ABC\x08\r");
    push_exp("ABC\x08 \x08\r\n", 1, 1);
    check_streams("bs");
    chk("bs_line_len", {len_a, 1'b0, len_b}, 8'h22);
    read_both(3'd2, 2'd1);
    chk("bs_rd", {rd_dat_a, rd_dat_b}, 16'h4342);
    ack_line(0);

    // DEL on empty buffer
    send_rx(8'h7F);
    cycles(30);
    check_streams("del_empty");
    chk("del_empty_len", {len_a, 1'b0, len_b}, 8'h00);
    chk("del_empty_lv", {lv_a, lv_b}, 2'b00);

    // Overflow on the depth-4 instance, and a non-printable byte ignored
    send_str("AB\x01CDE\r");
    push_exp("ABCDE\r\n", 1, 0);
    push_exp("ABCD\x07\r\n", 0, 1);
    check_streams("ovf");
    chk("ovf_len_a", len_a, 4'd5);
    chk("ovf_len_b", len_b, 3'd4);
    chk("ovf_flag", {ovf_a, ovf_b}, 2'b01);
    read_both(3'd4, 2'd3);
    chk("ovf_rd_last", {rd_dat_a, rd_dat_b}, 16'h4544);
    read_both(3'd6, 2'd0);
    chk("rd_out_of_range", rd_dat_a, 8'h00);
    ack_line(0);
    chk("ovf_ack_flag", {ovf_a, ovf_b}, 2'b00);

    // Second byte during echo is dropped; ACK with concurrent RX clears RX_DROP
    send_rx(8'h51);
    cycles(2);
    send_rx(8'h52);
    cycles(45);
    push_exp("Q", 1, 1);
    check_streams("drop");
    chk("drop_flag", {drop_a, drop_b}, 2'b11);
    chk("drop_len", {len_a, 1'b0, len_b}, 8'h11);
    send_str("\r");
    push_exp("\r\n", 1, 1);
    check_streams("drop_cr");
    chk("drop_line_valid", {lv_a, lv_b}, 2'b11);
    ack_line(1);
    chk("ack_rx_drop_clear", {drop_a, drop_b}, 2'b00);
    chk("ack_rx_lv", {lv_a, lv_b}, 2'b00);
    cycles(20);
    check_streams("ack_rx_no_echo");
    chk("ack_rx_len", {len_a, 1'b0, len_b}, 8'h00);

    // Reset while a line is held
    send_str("Z\r");
    push_exp("Z\r\n", 1, 1);
    check_streams("pre_rst");
    chk("pre_rst_lv", {lv_a, lv_b}, 2'b11);
    read_both(3'd0, 2'd0);
    rst = 1'b1;
    #1;
    chk("rst_line_lv", {lv_a, lv_b}, 2'b00);
    chk("rst_line_len", {len_a, 1'b0, len_b}, 8'h00);
    chk("rst_line_rd", {rd_dat_a, rd_dat_b}, 16'h0000);
    cycles(2);
    rst = 1'b0;

    // Reset in the cycle a send is firing
    send_rx(8'h4B);
    chk("pre_rst_send", {tx_send_a, tx_send_b}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_send_tx_send", {tx_send_a, tx_send_b}, 2'b00);
    chk("rst_send_tx_dat", {tx_dat_a, tx_dat_b}, 16'h0000);
    cycles(2);
    rst = 1'b0;
    got_a.delete(); got_b.delete();
    cycles(30);
    check_streams("rst_quiet");
    chk("rst_send_len", {len_a, 1'b0, len_b}, 8'h00);
    send_str("M");
    push_exp("M", 1, 1);
    check_streams("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
